// File: rtl/divisor_secuencial_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width
// and small helpers used by the controller.
package divisor_secuencial_pkg;

  localparam int ANCHO_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RESTA = 2'b01,
    FIN   = 2'b10
  } estado_t;

  // The unused code 2'b11 behaves as IDLE, so it is never reported as busy.
  function automatic logic estado_ocupado(input estado_t e);
    return (e == RESTA) || (e == FIN);
  endfunction

  function automatic logic es_cero(input logic [ANCHO_DEF-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/divisor_secuencial_unidad_resta.sv
// Combinational ANCHO-bit subtract unit: diferencia = minuendo - sustraendo,
// with borrow set when sustraendo > minuendo.
module unidad_resta
  import divisor_secuencial_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0] minuendo,
  input  logic [ANCHO-1:0] sustraendo,
  output logic [ANCHO-1:0] diferencia,
  output logic             borrow
);

  logic [ANCHO:0] suma;

  // Two's-complement add; a missing carry out means the subtraction borrowed.
  assign suma       = {1'b0, minuendo} + {1'b0, ~sustraendo} + {{ANCHO{1'b0}}, 1'b1};
  assign diferencia = suma[ANCHO-1:0];
  assign borrow     = ~suma[ANCHO];

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential unsigned divider: repeated subtraction, one trial per clock,
// with a start/busy/done handshake and registered quotient/remainder outputs.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ANCHO-1:0] dividendo,
  input  logic [ANCHO-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             div_cero
);

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] r_q, r_d;
  logic [ANCHO-1:0] d_q, d_d;
  logic [ANCHO-1:0] q_q, q_d;
  logic [ANCHO-1:0] cociente_q, cociente_d;
  logic [ANCHO-1:0] residuo_q, residuo_d;
  logic             div_cero_q, div_cero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [ANCHO-1:0] diferencia;
  logic             borrow;

  unidad_resta #(
    .ANCHO (ANCHO)
  ) u_resta (
    .minuendo   (r_q),
    .sustraendo (d_q),
    .diferencia (diferencia),
    .borrow     (borrow)
  );

  always_comb begin
    estado_d   = estado_q;
    r_d        = r_q;
    d_d        = d_q;
    q_d        = q_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    div_cero_d = div_cero_q;
    done_d     = 1'b0;

    case (estado_q)
      RESTA: begin
        if (!borrow) begin
          r_d = diferencia;
          q_d = q_q + ANCHO'(1);
        end else begin
          // Final trial borrowed: R and Q already hold the result.
          estado_d   = FIN;
          done_d     = 1'b1;
          cociente_d = q_q;
          residuo_d  = r_q;
          div_cero_d = 1'b0;
        end
      end
      FIN: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
        if (start) begin
          r_d = dividendo;
          d_d = divisor;
          q_d = '0;
          if (divisor == '0) begin
            estado_d   = FIN;
            done_d     = 1'b1;
            cociente_d = '1;
            residuo_d  = dividendo;
            div_cero_d = 1'b1;
          end else begin
            estado_d = RESTA;
          end
        end
      end
    endcase

    busy_d = estado_ocupado(estado_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      div_cero_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      r_q        <= r_d;
      d_q        <= d_d;
      q_q        <= q_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      div_cero_q <= div_cero_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cociente = cociente_q;
  assign residuo  = residuo_q;
  assign div_cero = div_cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: directed table, hand-written
// corner sequences, exhaustive sweep and random operations vs. a plain model.
module tb_divisor_secuencial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] cociente;
  logic [W-1:0] residuo;
  logic         div_cero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  divisor_secuencial #(.ANCHO(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .cociente  (cociente),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tabla [6];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic void modelo(input int a, input int b, output int q, output int r,
                                 output int dz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = q + 2;
    end
  endfunction

  // Issues one request, returns done latency (0 on timeout), whether busy stayed
  // high through cycles 1..lat, and busy/done in the cycle after FIN.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                        output int busy_ok, output int busy_after, output int done_after);
    @(negedge clk);
    start = 1'b1; dividendo = a; divisor = b;
    step();
    start = 1'b0; dividendo = W'($urandom); divisor = W'($urandom);
    lat = 0; busy_ok = 1; busy_after = -1; done_after = -1;
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      step();
    end
    if (lat != 0) begin
      step();
      busy_after = busy; done_after = done;
    end
  endtask

  int lat, bok, ba, da;
  int eq, er, edz, elat;

  initial begin
    rst_n = 1'b0; start = 1'b0; dividendo = '0; divisor = '0;

    tabla[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 5};
    tabla[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 17};
    tabla[2] = '{4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 2};
    tabla[3] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1};
    tabla[4] = '{4'd8,  4'd2, 4'd4,  4'd0, 1'b0, 6};
    tabla[5] = '{4'd3,  4'd9, 4'd0,  4'd3, 1'b0, 2};

    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cociente", cociente, 0);
    chk("reset_residuo", residuo, 0);
    chk("reset_div_cero", div_cero, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_div(tabla[i].a, tabla[i].b, lat, bok, ba, da);
      chk($sformatf("tab%0d_lat", i), lat, tabla[i].lat);
      chk($sformatf("tab%0d_cociente", i), cociente, tabla[i].q);
      chk($sformatf("tab%0d_residuo", i), residuo, tabla[i].r);
      chk($sformatf("tab%0d_div_cero", i), div_cero, tabla[i].dz);
      chk($sformatf("tab%0d_busy_during", i), bok, 1);
      chk($sformatf("tab%0d_busy_after", i), ba, 0);
      chk($sformatf("tab%0d_done_pulse", i), da, 0);
    end

    // 12/3 with starts in RESTA and FIN ignored, then held into IDLE and accepted.
    @(negedge clk);
    start = 1'b1; dividendo = 4'd12; divisor = 4'd3;
    step();                                   // cycle 1
    start = 1'b0;
    step();                                   // cycle 2
    start = 1'b1; dividendo = 4'd5; divisor = 4'd5;
    step();                                   // cycle 3
    start = 1'b0;
    step(); step();                           // cycle 5
    chk("ign_no_early_done", done, 0);
    step();                                   // cycle 6 (FIN)
    chk("ign_done", done, 1);
    chk("ign_cociente", cociente, 4);
    chk("ign_residuo", residuo, 0);
    start = 1'b1; dividendo = 4'd5; divisor = 4'd5;
    step();                                   // cycle 7 (IDLE)
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_done", done, 0);
    step();                                   // cycle 8
    start = 1'b0;
    chk("acc_busy", busy, 1);
    step();                                   // cycle 9
    chk("acc_no_early_done", done, 0);
    step();                                   // cycle 10 (FIN of 5/5)
    chk("acc_done", done, 1);
    chk("acc_cociente", cociente, 1);
    chk("acc_residuo", residuo, 0);
    step();

    // 14/1 aborted by reset in cycle 6.
    @(negedge clk);
    start = 1'b1; dividendo = 4'd14; divisor = 4'd1;
    step();
    start = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 1; c <= 6; c++) begin
        if (done === 1'b1) seen_done = 1;
        if (c < 6) step();
      end
      rst_n = 1'b0;
      step();                                 // cycle 7
      if (done === 1'b1) seen_done = 1;
      chk("rst_no_done", seen_done, 0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_cociente", cociente, 0);
    chk("rst_residuo", residuo, 0);
    chk("rst_div_cero", div_cero, 0);
    rst_n = 1'b1;
    do_div(4'd6, 4'd2, lat, bok, ba, da);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_cociente", cociente, 3);
    chk("post_rst_residuo", residuo, 0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        modelo(a, b, eq, er, edz, elat);
        do_div(W'(a), W'(b), lat, bok, ba, da);
        chk($sformatf("sw_%0d_%0d_lat", a, b), lat, elat);
        chk($sformatf("sw_%0d_%0d_cociente", a, b), cociente, eq);
        chk($sformatf("sw_%0d_%0d_residuo", a, b), residuo, er);
        chk($sformatf("sw_%0d_%0d_div_cero", a, b), div_cero, edz);
      end
    end

    // Random operations with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      int a, b, gap;
      a = $urandom_range(15); b = $urandom_range(15); gap = $urandom_range(3);
      for (int g = 0; g < gap; g++) step();
      modelo(a, b, eq, er, edz, elat);
      do_div(W'(a), W'(b), lat, bok, ba, da);
      chk($sformatf("rnd%0d_lat", n), lat, elat);
      chk($sformatf("rnd%0d_cociente", n), cociente, eq);
      chk($sformatf("rnd%0d_residuo", n), residuo, er);
      chk($sformatf("rnd%0d_div_cero", n), div_cero, edz);
      chk($sformatf("rnd%0d_busy", n), bok, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
